// File: rtl/fuse_pkg.sv
// Shared types and defaults for the fuse row loader.
// The state enum always carries PARITY/ERR; they are only reachable when FUSE_PARITY_EN is defined.
package fuse_pkg;

    localparam int ROW_W_DEF  = 96;
    localparam int NROWS_DEF  = 160;   // 32 macrocells x 5 product terms
    localparam int ADDR_W_DEF = 8;

    localparam logic [0:ROW_W_DEF-1] ROW_ERASED = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_PARITY,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/fuse_row_loader_if.sv
// Serial fuse bit input and row write bus of the fuse row loader.
// master = loader side, slave = bitstream source / fuse storage side.
interface fuse_row_loader_if
    import fuse_pkg::*;
#(
    parameter int ROW_W  = ROW_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              bit_valid;
    logic              bit_data;
    logic              bit_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [0:ROW_W-1]  wr_data;
    logic              wr_busy;

    modport master (
        input  bit_valid, bit_data, wr_busy,
        output bit_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        output bit_valid, bit_data, wr_busy,
        input  bit_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/fuse_row_shifter.sv
// Packs accepted serial bits into one row, index 0 = first bit, and keeps a running XOR
// so the trailing even-parity bit can be judged the cycle it arrives.
module fuse_row_shifter
    import fuse_pkg::*;
#(
    parameter int ROW_W = ROW_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             take,
    input  logic             bit_data,
    output logic [0:ROW_W-1] row,
    output logic             row_full,
    output logic             parity_ok
);
    localparam int CNT_W = $clog2(ROW_W + 1);

    logic [CNT_W-1:0] cnt;
    logic             par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '1;
            cnt <= '0;
            par <= 1'b0;
        end else if (clr) begin
            row <= '1;
            cnt <= '0;
            par <= 1'b0;
        end else if (take) begin
            row[cnt] <= bit_data;
            cnt      <= cnt + 1'b1;
            par      <= par ^ bit_data;
        end
    end

    // High while the last bit of the row is being accepted.
    assign row_full  = take && (cnt == CNT_W'(ROW_W - 1));
    assign parity_ok = ~(par ^ bit_data);

endmodule

// File: rtl/fuse_row_loader.sv
// Fuse row loader: serial bitstream -> ROW_W-bit rows written at sequential addresses.
// Optional FUSE_PARITY_EN adds a trailing even-parity bit per row and an ERR state.
module fuse_row_loader
    import fuse_pkg::*;
#(
    parameter int ROW_W  = ROW_W_DEF,
    parameter int NROWS  = NROWS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    fuse_row_loader_if.master bus,
    output logic              busy,
    output logic              done,
    output logic              error
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              clr, take, row_full, parity_ok;
    logic [0:ROW_W-1]  row;

    fuse_row_shifter #(.ROW_W(ROW_W)) u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .take      (take),
        .bit_data  (bus.bit_data),
        .row       (row),
        .row_full  (row_full),
        .parity_ok (parity_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        clr     = 1'b0;
        take    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_SHIFT;
                    addr_d  = '0;
                    clr     = 1'b1;
                end
            end
            S_SHIFT: begin
                take = bus.bit_valid;
`ifdef FUSE_PARITY_EN
                if (row_full) state_d = S_PARITY;
`else
                if (row_full) state_d = S_WRITE;
`endif
            end
`ifdef FUSE_PARITY_EN
            S_PARITY: begin
                if (bus.bit_valid) state_d = parity_ok ? S_WRITE : S_ERR;
            end
            S_ERR: begin
                if (start) begin
                    state_d = S_SHIFT;
                    addr_d  = '0;
                    clr     = 1'b1;
                end
            end
`endif
            S_WRITE: begin
                if (!bus.wr_busy) begin
                    // Address never advances past the last row, so it cannot wrap.
                    if (addr_q == ADDR_W'(NROWS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        clr     = 1'b1;
                        state_d = S_SHIFT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.bit_ready = (state_q == S_SHIFT) || (state_q == S_PARITY);
    assign bus.wr_en     = (state_q == S_WRITE);
    assign bus.wr_addr   = addr_q;
    assign bus.wr_data   = row;
    assign busy          = (state_q == S_SHIFT) || (state_q == S_PARITY) || (state_q == S_WRITE);
    assign done          = (state_q == S_DONE);

`ifdef FUSE_PARITY_EN
    assign error = (state_q == S_ERR);
`else
    assign error = 1'b0;
    logic unused_parity_ok;
    assign unused_parity_ok = parity_ok;
`endif

endmodule
